aes_rk_store: RTL and testbench
===============================

# aes_rk_store

Round-key buffer between the AES-128 key expansion stage and the cipher/inverse-cipher round datapath.
- Captures the 11 round keys (rounds 0..10) that key expansion emits as four 32-bit words per round.
- Holds them until flushed.
- Replays them on request in forward order (0→10, encryption) or reverse order (10→0, decryption) over a valid/ready handshake.
- Lets one expansion serve any number of blocks.

## Interface
- DATA_WIDTH, 32, width of one key word
- NUM_ROUNDS, 10, last round index; NUM_ROUNDS+1 keys stored
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all stored keys; highest priority
- ld_valid  in  1  round-key word set valid from key expansion
- ld_word_0..ld_word_3  in  DATA_WIDTH each  round-key words, word 0 = most significant
- ld_ready  out  1  buffer accepts a load beat this cycle
- keys_ready  out  1  all NUM_ROUNDS+1 keys stored
- rd_start  in  1  pulse: begin a replay
- rd_dir  in  1  sampled with rd_start; 0 = forward, 1 = reverse
- rk_valid  out  1  rk_data holds a round key
- rd_ready  in  1  consumer accepts rk_data
- rk_data  out  4*DATA_WIDTH  round key {word0,word1,word2,word3}
- rk_round  out  4  round index of rk_data
- rk_last  out  1  current beat is the final key of the replay

## Operation
- States: S_EMPTY, S_LOAD, S_READY, S_READ.
- S_EMPTY:
  - ld_ready=1, wr_cnt=0.
  - A ld_valid beat writes slot 0, then goes to S_LOAD.
- S_LOAD:
  - ld_ready=1.
  - Each ld_valid beat writes slot wr_cnt and increments wr_cnt.
  - The beat writing slot NUM_ROUNDS goes to S_READY.
- S_READY:
  - keys_ready=1, ld_ready=0.
  - rd_start latches rd_dir.
  - Sets ptr=0 (forward) or ptr=NUM_ROUNDS (reverse), then goes to S_READ.
- S_READ:
  - rk_valid=1; rk_data=slot[ptr]; rk_round=ptr.
  - rk_last=1 when ptr=NUM_ROUNDS (forward) or ptr=0 (reverse).
  - A handshake (rk_valid & rd_ready) advances ptr by ±1.
  - The handshake on rk_last returns to S_READY.
  - keys_ready stays 1 throughout.
- Keys persist across replays; any number of replays is allowed per load.
- flush, in any state: next cycle S_EMPTY, wr_cnt=0, ptr=0, all outputs at reset values. Storage contents are don't-care.
- Ignored inputs:
  - rd_start outside S_READY, including during S_READ.
  - ld_valid when ld_ready=0. Key expansion must hold the beat; it is not dropped silently by protocol.
- flush and ld_valid in the same cycle: flush wins, and the beat is not written.
- flush and a read handshake in the same cycle: flush wins.
- wr_cnt and ptr are 4-bit. ptr never leaves 0..NUM_ROUNDS; no wrap.

## Timing
- Reset values: ld_ready=1 (S_EMPTY), keys_ready=0, rk_valid=0, rk_last=0, rk_round=0, rk_data=0.
- rk_data is forced to 0 whenever rk_valid=0. Storage registers are not reset.
- Load:
  - One beat per cycle at full rate.
  - keys_ready rises the cycle after the 11th beat.
  - Minimum load is 11 cycles.
- Replay:
  - rk_valid rises the cycle after rd_start.
  - rk_data and rk_round change only on a handshake edge.
  - With rd_ready held high, 11 keys take 11 consecutive cycles.
  - A new rd_start is accepted the cycle after the last handshake.
- rk_data is a combinational mux of registered ptr over registered storage; there is no extra output pipeline stage.
- rd_ready low holds rk_valid, rk_data, rk_round and rk_last stable.

## Structure
- Shared package aes_pkg holds:
  - state encoding localparams (S_EMPTY..S_READ)
  - AES_NR=10
  - round-index width (4)
  - key word width
- Sub-module aes_rk_bank: (NUM_ROUNDS+1)×(4*DATA_WIDTH) register file with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The top level contains the FSM, wr_cnt, ptr, direction latch and output gating.

## Test plan
- Reset then load the FIPS-197 expansion of 2b7e151628aed2a6abf7158809cf4f3c over 11 back-to-back beats:
  - keys_ready=1 the cycle after beat 11, ld_ready=0.
- Forward replay with rd_ready=1:
  - rk_round 0..10 on consecutive cycles.
  - Round 0 data is 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Round 10 data is d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with rk_last=1.
- Reverse replay with rd_ready toggling 1,0,1,0…:
  - First beat is round 10 (d014f9a8…); data holds stable while rd_ready=0.
  - rk_last on round 0; 21 cycles total.
- ld_valid with gaps and a flush asserted after 5 beats, in the same cycle as the 6th ld_valid:
  - S_EMPTY, keys_ready=0, beat not written.
  - Full reload then replays the new key correctly.
- rd_start asserted mid-replay at round 4, and rd_start asserted in S_LOAD:
  - Both ignored; replay continues to round 10 unchanged.
- rst_n dropped mid-replay at round 6:
  - All outputs at reset values immediately, asynchronously.
  - After release, ld_ready=1 and keys_ready=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round-key buffer: state encoding,
// round count and widths.
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int RND_W      = 4;
  localparam int KEY_WORD_W = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_LOAD  = ST_LOAD,
    S_READY = ST_READY,
    S_READ  = ST_READ
  } rk_state_t;

endpackage

// File: rtl/aes_rk_store_if.sv
// Load and replay handshake bundle between key expansion, the round-key
// store and the round datapath.
interface aes_rk_store_if
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_WORD_W
) ();

  logic                    ld_valid;
  logic [DATA_WIDTH-1:0]   ld_word_0;
  logic [DATA_WIDTH-1:0]   ld_word_1;
  logic [DATA_WIDTH-1:0]   ld_word_2;
  logic [DATA_WIDTH-1:0]   ld_word_3;
  logic                    ld_ready;
  logic                    keys_ready;
  logic                    rd_start;
  logic                    rd_dir;
  logic                    rk_valid;
  logic                    rd_ready;
  logic [4*DATA_WIDTH-1:0] rk_data;
  logic [RND_W-1:0]        rk_round;
  logic                    rk_last;

  modport slave (
    input  ld_valid, ld_word_0, ld_word_1, ld_word_2, ld_word_3,
    input  rd_start, rd_dir, rd_ready,
    output ld_ready, keys_ready, rk_valid, rk_data, rk_round, rk_last
  );

  modport master (
    output ld_valid, ld_word_0, ld_word_1, ld_word_2, ld_word_3,
    output rd_start, rd_dir, rd_ready,
    input  ld_ready, keys_ready, rk_valid, rk_data, rk_round, rk_last
  );

endinterface

// File: rtl/aes_rk_store_bank.sv
// Round-key register file: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module aes_rk_bank #(
  parameter int DEPTH = 11,
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/aes_rk_store.sv
// Round-key buffer: captures the 11 expanded round keys once, then replays
// them forward or reverse any number of times until flushed.
//
// state   | meaning
// S_EMPTY | no keys held, waiting for the first load beat
// S_LOAD  | loading keys 1..NUM_ROUNDS, wr_cnt is the next slot
// S_READY | all keys held, waiting for rd_start
// S_READ  | replaying, ptr is the key currently presented
module aes_rk_store
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_WORD_W,
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  aes_rk_store_if.slave  bus
);

  localparam int               KW      = 4 * DATA_WIDTH;
  localparam logic [RND_W-1:0] LAST    = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] LAST_M1 = RND_W'(NUM_ROUNDS - 1);
  localparam logic [RND_W-1:0] ONE     = RND_W'(1);

  rk_state_t        state;
  logic [RND_W-1:0] wr_cnt;
  logic [RND_W-1:0] ptr;
  logic             dir_rev;
  logic             ld_ready_q;
  logic             keys_ready_q;
  logic             rk_valid_q;
  logic             rk_last_q;

  logic             we;
  logic [KW-1:0]    wdata;
  logic [KW-1:0]    rdata;

  // A flush in the same cycle as a load beat must not disturb storage.
  assign we    = bus.ld_valid & ld_ready_q & ~flush;
  assign wdata = {bus.ld_word_0, bus.ld_word_1, bus.ld_word_2, bus.ld_word_3};

  aes_rk_bank #(
    .DEPTH (NUM_ROUNDS + 1),
    .WIDTH (KW),
    .AW    (RND_W)
  ) u_bank (
    .clk   (clk),
    .we    (we),
    .waddr (wr_cnt),
    .wdata (wdata),
    .raddr (ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_EMPTY;
      wr_cnt       <= '0;
      ptr          <= '0;
      dir_rev      <= 1'b0;
      ld_ready_q   <= 1'b1;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_last_q    <= 1'b0;
    end else if (flush) begin
      state        <= S_EMPTY;
      wr_cnt       <= '0;
      ptr          <= '0;
      dir_rev      <= 1'b0;
      ld_ready_q   <= 1'b1;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_last_q    <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (bus.ld_valid) begin
            wr_cnt <= ONE;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid) begin
            if (wr_cnt == LAST) begin
              wr_cnt       <= '0;
              ld_ready_q   <= 1'b0;
              keys_ready_q <= 1'b1;
              state        <= S_READY;
            end else begin
              wr_cnt <= wr_cnt + ONE;
            end
          end
        end
        S_READY: begin
          if (bus.rd_start) begin
            dir_rev    <= bus.rd_dir;
            ptr        <= bus.rd_dir ? LAST : '0;
            rk_valid_q <= 1'b1;
            rk_last_q  <= 1'b0;
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (bus.rd_ready) begin
            if (rk_last_q) begin
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
              state      <= S_READY;
            end else if (dir_rev) begin
              ptr       <= ptr - ONE;
              rk_last_q <= (ptr == ONE);
            end else begin
              ptr       <= ptr + ONE;
              rk_last_q <= (ptr == LAST_M1);
            end
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready_q;
  assign bus.keys_ready = keys_ready_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_last    = rk_last_q;
  assign bus.rk_round   = rk_valid_q ? ptr : '0;
  assign bus.rk_data    = rk_valid_q ? rdata : '0;

endmodule

// File: tb/tb_aes_rk_store.sv
// Scoreboard bench for aes_rk_store: a key-array model predicts every replay
// beat; a negedge monitor compares whatever the DUT presents.
module tb_aes_rk_store;

  localparam int DW = 32;
  localparam int NR = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  aes_rk_store_if #(.DATA_WIDTH(DW)) bus ();

  aes_rk_store #(.DATA_WIDTH(DW), .NUM_ROUNDS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_mem [0:NR];
  logic [127:0] next_key  [0:NR];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: any presented key must match the head of the scoreboard;
  // it is consumed only when the handshake completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rk_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: rk_valid=1 round %0d, expected none", bus.rk_round);
        end else begin
          check("rk_round", 128'(bus.rk_round), 128'(sb[0].rnd));
          check("rk_data",  bus.rk_data, sb[0].data);
          check("rk_last",  128'(bus.rk_last), 128'(sb[0].last));
          if (bus.rd_ready && !flush) sb.delete(0);
        end
      end else begin
        check("rk_data_gated", bus.rk_data, 128'(0));
      end
    end
  end

  function automatic bit ready_pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic push_replay(input bit rev);
    for (int k = 0; k <= NR; k++) begin
      exp_t e;
      int   r;
      r      = rev ? NR - k : k;
      e.rnd  = 4'(r);
      e.data = model_mem[r];
      e.last = (k == NR);
      sb.push_back(e);
    end
  endtask

  task automatic drive_beat(input logic [127:0] k);
    bus.ld_word_0 = k[127:96];
    bus.ld_word_1 = k[95:64];
    bus.ld_word_2 = k[63:32];
    bus.ld_word_3 = k[31:0];
  endtask

  task automatic check_idle_outputs(input string tag, input bit keys);
    check({tag, "_ld_ready"},   128'(bus.ld_ready),   128'(!keys));
    check({tag, "_keys_ready"}, 128'(bus.keys_ready), 128'(keys));
    check({tag, "_rk_valid"},   128'(bus.rk_valid),   128'(0));
  endtask

  task automatic load_key(input bit gaps, input bit poke_rd_start);
    for (int i = 0; i <= NR; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          bus.ld_valid = 1'b0;
          bus.rd_start = 1'b0;
        end
      end
      @(posedge clk); #1;
      drive_beat(next_key[i]);
      bus.ld_valid = 1'b1;
      bus.rd_start = poke_rd_start && (i == 4);
      bus.rd_dir   = 1'($urandom_range(0, 1));
      if (i == NR) check_idle_outputs("pre_last_beat", 1'b0);
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    bus.rd_start = 1'b0;
    for (int i = 0; i <= NR; i++) model_mem[i] = next_key[i];
    @(negedge clk);
    check_idle_outputs("after_load", 1'b1);
  endtask

  task automatic flush_after_five();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
      end
      @(posedge clk); #1;
      drive_beat({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.ld_valid = 1'b1;
    end
    @(posedge clk); #1;
    drive_beat({$urandom(), $urandom(), $urandom(), $urandom()});
    bus.ld_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_flush", 1'b0);
  endtask

  task automatic replay(input bit rev, input int mode, input int inject_round, input int exp_cycles);
    int cyc      = 0;
    int k        = 0;
    bit done     = 1'b0;
    bit inj_now  = 1'b0;
    bit injected = 1'b0;
    push_replay(rev);
    @(posedge clk); #1;
    bus.rd_start = 1'b1;
    bus.rd_dir   = rev;
    bus.rd_ready = 1'b0;
    @(posedge clk); #1;
    bus.rd_start = 1'b0;
    bus.rd_ready = ready_pat(mode, 0);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.rk_valid) begin
        cyc++;
        if (inject_round >= 0 && !injected && int'(bus.rk_round) == inject_round) inj_now = 1'b1;
      end else begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        k++;
        bus.rd_ready = ready_pat(mode, k);
        bus.rd_start = 1'b0;
        if (inj_now) begin
          bus.rd_start = 1'b1;
          bus.rd_dir   = !rev;
          inj_now      = 1'b0;
          injected     = 1'b1;
        end
      end
    end
    bus.rd_ready = 1'b0;
    bus.rd_start = 1'b0;
    if (!done) fail_now("replay_timeout");
    check("sb_drained", 128'(sb.size()), 128'(0));
    check("keys_ready_after_replay", 128'(bus.keys_ready), 128'(1));
    if (exp_cycles > 0) check("replay_cycles", 128'(cyc), 128'(exp_cycles));
    sb.delete();
  endtask

  task automatic reset_mid_replay();
    bit hit = 1'b0;
    push_replay(1'b0);
    @(posedge clk); #1;
    bus.rd_start = 1'b1;
    bus.rd_dir   = 1'b0;
    @(posedge clk); #1;
    bus.rd_start = 1'b0;
    bus.rd_ready = 1'b1;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_round == 4'd6) hit = 1'b1;
    end
    if (!hit) fail_now("wait_round6");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ld_ready",   128'(bus.ld_ready),   128'(1));
    check("rst_keys_ready", 128'(bus.keys_ready), 128'(0));
    check("rst_rk_valid",   128'(bus.rk_valid),   128'(0));
    check("rst_rk_last",    128'(bus.rk_last),    128'(0));
    check("rst_rk_round",   128'(bus.rk_round),   128'(0));
    check("rst_rk_data",    bus.rk_data,          128'(0));
    sb.delete();
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_rst", 1'b0);
  endtask

  initial begin
    logic [127:0] fips [0:NR];
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    bus.ld_valid = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_dir   = 1'b0;
    bus.rd_ready = 1'b0;
    drive_beat(128'(0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_ld_ready",   128'(bus.ld_ready),   128'(1));
    check("reset_keys_ready", 128'(bus.keys_ready), 128'(0));
    check("reset_rk_valid",   128'(bus.rk_valid),   128'(0));
    check("reset_rk_last",    128'(bus.rk_last),    128'(0));
    check("reset_rk_round",   128'(bus.rk_round),   128'(0));
    check("reset_rk_data",    bus.rk_data,          128'(0));
    rst_n = 1'b1;

    for (int i = 0; i <= NR; i++) next_key[i] = fips[i];
    load_key(1'b0, 1'b0);
    replay(1'b0, 0, -1, 11);
    replay(1'b1, 1, -1, 21);
    replay(1'b0, 2, -1, 0);
    replay(1'b1, 2, -1, 0);

    flush_after_five();
    for (int i = 0; i <= NR; i++) next_key[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(1'b1, 1'b1);
    replay(1'b0, 0, 4, 11);
    replay(1'b1, 2, 4, 0);
    replay(1'b0, 1, -1, 21);

    reset_mid_replay();
    for (int i = 0; i <= NR; i++) next_key[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(1'b1, 1'b0);
    replay(1'b1, 0, -1, 11);
    replay(1'b0, 2, -1, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
